// File: rtl/neighbor_builder_if.sv
// neighbor_builder_if: control handshake plus RAM_OBJ/RAM_NBR buses for neighbor_builder.
// Signals:
//   start, vertex_count, face_count       controller -> builder
//   busy, done, overflow, bad_index       builder -> controller
//   RAM_OBJ_Do, RAM_NBR_Do                RAM -> builder (synchronous read data)
//   RAM_*_EN, RAM_*_A, RAM_*_WE, RAM_*_Di builder -> RAM
// Modports: master = controller/RAM side, slave = neighbor_builder.
interface neighbor_builder_if #(
   parameter int ADDR_WIDTH = 9
);
   logic                  start;
   logic [31:0]           vertex_count;
   logic [31:0]           face_count;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic                  bad_index;
   logic [31:0]           RAM_OBJ_Do;
   logic                  RAM_OBJ_EN;
   logic [ADDR_WIDTH-1:0] RAM_OBJ_A;
   logic [3:0]            RAM_OBJ_WE;
   logic [31:0]           RAM_OBJ_Di;
   logic [31:0]           RAM_NBR_Do;
   logic                  RAM_NBR_EN;
   logic [ADDR_WIDTH-1:0] RAM_NBR_A;
   logic [3:0]            RAM_NBR_WE;
   logic [31:0]           RAM_NBR_Di;

   modport master (
      output start, vertex_count, face_count, RAM_OBJ_Do, RAM_NBR_Do,
      input  busy, done, overflow, bad_index,
      input  RAM_OBJ_EN, RAM_OBJ_A, RAM_OBJ_WE, RAM_OBJ_Di,
      input  RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE, RAM_NBR_Di
   );

   modport slave (
      input  start, vertex_count, face_count, RAM_OBJ_Do, RAM_NBR_Do,
      output busy, done, overflow, bad_index,
      output RAM_OBJ_EN, RAM_OBJ_A, RAM_OBJ_WE, RAM_OBJ_Di,
      output RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE, RAM_NBR_Di
   );
endinterface

// File: rtl/neighbor_builder.sv
// neighbor_builder: builds the per-vertex adjacency table in RAM_NBR from the triangle list in RAM_OBJ.
// Ports:
//   clk    clock, all state updates on posedge
//   rst_n  asynchronous active-low reset
//   bus    neighbor_builder_if.slave: start/vertex_count/face_count in, busy/done/overflow/bad_index out,
//          RAM_OBJ (read-only) and RAM_NBR (read/write) synchronous-read RAM buses
// Entry layout: vertex v at base v*MAX_NEIGHBOR_COUNT, word base = count, base+1.. = 1-indexed neighbours.
// Optional: define NBR_BUILDER_INDEX_CHECK_EN to skip faces holding an index of 0 or above V and flag bad_index.
module neighbor_builder #(
   parameter int MAX_NEIGHBOR_COUNT = 10,
   parameter int ADDR_WIDTH         = 9
) (
   input logic               clk,
   input logic               rst_n,
   neighbor_builder_if.slave bus
);
   localparam int              AW     = ADDR_WIDTH;
   localparam logic [31:0]     LIM    = 32'(MAX_NEIGHBOR_COUNT - 1);
   localparam logic [AW-1:0]   STRIDE = AW'(MAX_NEIGHBOR_COUNT);
   localparam logic [AW-1:0]   ONE    = AW'(1);

   typedef enum logic [3:0] {IDLE, CLEAR, FACE_RD, EDGE, CNT_RD, SCAN, APPEND, CNT_WR, FINISH} state_t;

   state_t        r_state, w_next;
   logic [31:0]   r_f, r_j, r_cnt, r_a, r_b, r_c;
   logic [AW-1:0] r_clr_a, r_obj_a;
   logic [1:0]    r_k;
   logic [2:0]    r_e;
   logic          r_ovf, r_bad;
   logic [31:0]   w_src, w_dst;
   logic [AW-1:0] w_base;
   logic          w_face_end, w_hit, w_scan_rd, w_fits, w_bad;

   // edge order a->b, a->c, b->a, b->c, c->a, c->b selected by r_e
   assign w_src      = r_e < 3'd2 ? r_a : r_e < 3'd4 ? r_b : r_c;
   assign w_dst      = (r_e == 3'd2 || r_e == 3'd4) ? r_a : (r_e == 3'd0 || r_e == 3'd5) ? r_b : r_c;
   assign w_base     = AW'((w_src - 32'd1) * 32'(MAX_NEIGHBOR_COUNT));
   assign w_face_end = r_f == bus.face_count;
   // in SCAN, r_j==0 means RAM_NBR_Do carries the count; afterwards it carries neighbour word r_j
   assign w_hit      = r_j != 32'd0 && bus.RAM_NBR_Do == w_dst;
   assign w_scan_rd  = r_j == 32'd0 ? bus.RAM_NBR_Do != 32'd0 : !w_hit && r_j != r_cnt;
   assign w_fits     = r_cnt < LIM;

`ifdef NBR_BUILDER_INDEX_CHECK_EN
   // evaluated in the last FACE_RD cycle, where c is still on RAM_OBJ_Do
   assign w_bad = r_a == 32'd0 || r_a > bus.vertex_count || r_b == 32'd0 || r_b > bus.vertex_count ||
                  bus.RAM_OBJ_Do == 32'd0 || bus.RAM_OBJ_Do > bus.vertex_count;
`else
   assign w_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.start ? CLEAR : IDLE;
         CLEAR:   w_next = bus.vertex_count == 32'd0 ? FINISH :
                           r_j == bus.vertex_count - 32'd1 ? FACE_RD : CLEAR;
         FACE_RD: w_next = r_k == 2'd0 && w_face_end ? FINISH : r_k == 2'd3 ? EDGE : FACE_RD;
         EDGE:    w_next = r_e == 3'd6 ? FACE_RD : w_src == w_dst ? EDGE : CNT_RD;
         CNT_RD:  w_next = SCAN;
         SCAN:    w_next = w_hit ? EDGE : w_scan_rd ? SCAN : APPEND;
         APPEND:  w_next = w_fits ? CNT_WR : EDGE;
         CNT_WR:  w_next = EDGE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_f     <= '0;
         r_j     <= '0;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= '0;
         r_clr_a <= '0;
         r_obj_a <= '0;
         r_k     <= '0;
         r_e     <= '0;
         r_ovf   <= 1'b0;
         r_bad   <= 1'b0;
      end else begin
         case (r_state)
            IDLE:
               if (bus.start) begin
                  r_ovf   <= 1'b0;
                  r_bad   <= 1'b0;
                  r_j     <= '0;
                  r_f     <= '0;
                  r_k     <= '0;
                  r_clr_a <= '0;
                  r_obj_a <= AW'(bus.vertex_count * 32'd3 + 32'd1);
               end
            CLEAR: begin
               r_j     <= r_j + 32'd1;
               r_clr_a <= r_clr_a + STRIDE;
            end
            FACE_RD: begin
               r_k <= r_k + 2'd1;
               if (r_k != 2'd3) r_obj_a <= r_obj_a + ONE;
               if (r_k == 2'd1) r_a <= bus.RAM_OBJ_Do;
               if (r_k == 2'd2) r_b <= bus.RAM_OBJ_Do;
               if (r_k == 2'd3) begin
                  r_c <= bus.RAM_OBJ_Do;
                  // a rejected face jumps straight to the end-of-face edge slot
                  r_e <= w_bad ? 3'd6 : 3'd0;
                  if (w_bad) r_bad <= 1'b1;
               end
            end
            EDGE:
               if (r_e == 3'd6) begin
                  r_f <= r_f + 32'd1;
                  r_k <= '0;
               end else if (w_src == w_dst) r_e <= r_e + 3'd1;
               else r_j <= '0;
            SCAN: begin
               if (r_j == 32'd0) r_cnt <= bus.RAM_NBR_Do;
               if (w_scan_rd) r_j <= r_j + 32'd1;
               if (w_hit) r_e <= r_e + 3'd1;
            end
            APPEND:
               if (!w_fits) begin
                  r_ovf <= 1'b1;
                  r_e   <= r_e + 3'd1;
               end
            CNT_WR: r_e <= r_e + 3'd1;
            default: ;
         endcase
      end

   assign bus.busy       = r_state != IDLE;
   assign bus.done       = r_state == FINISH;
   assign bus.overflow   = r_ovf;
   assign bus.bad_index  = r_bad;
   assign bus.RAM_OBJ_WE = 4'h0;
   assign bus.RAM_OBJ_Di = 32'd0;

   always_comb begin
      bus.RAM_OBJ_EN = 1'b0;
      bus.RAM_OBJ_A  = '0;
      bus.RAM_NBR_EN = 1'b0;
      bus.RAM_NBR_A  = '0;
      bus.RAM_NBR_WE = 4'h0;
      bus.RAM_NBR_Di = 32'd0;
      case (r_state)
         CLEAR: begin
            bus.RAM_NBR_EN = bus.vertex_count != 32'd0;
            bus.RAM_NBR_WE = {4{bus.vertex_count != 32'd0}};
            bus.RAM_NBR_A  = r_clr_a;
         end
         FACE_RD: begin
            bus.RAM_OBJ_EN = r_k != 2'd3 && !w_face_end;
            bus.RAM_OBJ_A  = r_obj_a;
         end
         CNT_RD: begin
            bus.RAM_NBR_EN = 1'b1;
            bus.RAM_NBR_A  = w_base;
         end
         SCAN: begin
            bus.RAM_NBR_EN = w_scan_rd;
            bus.RAM_NBR_A  = w_base + AW'(r_j) + ONE;
         end
         APPEND: begin
            bus.RAM_NBR_EN = w_fits;
            bus.RAM_NBR_WE = {4{w_fits}};
            bus.RAM_NBR_A  = w_base + AW'(r_cnt) + ONE;
            bus.RAM_NBR_Di = w_dst;
         end
         CNT_WR: begin
            bus.RAM_NBR_EN = 1'b1;
            bus.RAM_NBR_WE = 4'hF;
            bus.RAM_NBR_A  = w_base;
            bus.RAM_NBR_Di = r_cnt + 32'd1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_neighbor_builder.sv
// tb_neighbor_builder: scoreboard bench driving two builders (10 and 4 words per entry) from shared stimulus.
module tb_neighbor_builder;
   localparam int AW = 9;

   typedef struct packed {
      int          addr;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start;
   logic [31:0] vcount, fcount;
   logic        fill;
   logic [31:0] obj  [512];
   logic [31:0] nbr0 [512];
   logic [31:0] nbr1 [512];
   int          faces [8][3];
   exp_t        q0[$], q1[$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   neighbor_builder_if #(.ADDR_WIDTH(AW)) b0 ();
   neighbor_builder_if #(.ADDR_WIDTH(AW)) b1 ();

   neighbor_builder #(.MAX_NEIGHBOR_COUNT(10), .ADDR_WIDTH(AW)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   neighbor_builder #(.MAX_NEIGHBOR_COUNT(4),  .ADDR_WIDTH(AW)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

   assign b0.start = start;
   assign b1.start = start;
   assign b0.vertex_count = vcount;
   assign b1.vertex_count = vcount;
   assign b0.face_count = fcount;
   assign b1.face_count = fcount;

   // synchronous-read RAMs; fill preloads stale junk into both neighbour RAMs
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 512; i++) begin
            nbr0[i] <= 32'hDEAD_0000 + 32'(i);
            nbr1[i] <= 32'hBEEF_0000 + 32'(i);
         end
      end else begin
         if (b0.RAM_NBR_EN && b0.RAM_NBR_WE == 4'hF) nbr0[b0.RAM_NBR_A] <= b0.RAM_NBR_Di;
         if (b1.RAM_NBR_EN && b1.RAM_NBR_WE == 4'hF) nbr1[b1.RAM_NBR_A] <= b1.RAM_NBR_Di;
      end
      if (b0.RAM_NBR_EN) b0.RAM_NBR_Do <= nbr0[b0.RAM_NBR_A];
      if (b1.RAM_NBR_EN) b1.RAM_NBR_Do <= nbr1[b1.RAM_NBR_A];
      if (b0.RAM_OBJ_EN) b0.RAM_OBJ_Do <= obj[b0.RAM_OBJ_A];
      if (b1.RAM_OBJ_EN) b1.RAM_OBJ_Do <= obj[b1.RAM_OBJ_A];
   end

   function automatic logic [95:0] outs0();
      return {b0.busy, b0.done, b0.overflow, b0.bad_index, b0.RAM_OBJ_EN, b0.RAM_OBJ_A, b0.RAM_OBJ_WE,
              b0.RAM_OBJ_Di, b0.RAM_NBR_EN, b0.RAM_NBR_A, b0.RAM_NBR_WE, b0.RAM_NBR_Di};
   endfunction

   function automatic logic [95:0] outs1();
      return {b1.busy, b1.done, b1.overflow, b1.bad_index, b1.RAM_OBJ_EN, b1.RAM_OBJ_A, b1.RAM_OBJ_WE,
              b1.RAM_OBJ_Di, b1.RAM_NBR_EN, b1.RAM_NBR_A, b1.RAM_NBR_WE, b1.RAM_NBR_Di};
   endfunction

   task automatic set_face(input int f, input int a, input int b, input int c);
      faces[f][0] = a;
      faces[f][1] = b;
      faces[f][2] = c;
   endtask

   task automatic load_obj(input int v, input int nf);
      for (int i = 0; i <= 3 * v; i++) obj[i] = 32'h0000_0BAD;
      for (int f = 0; f < nf; f++)
         for (int k = 0; k < 3; k++) obj[3 * v + 1 + 3 * f + k] = 32'(faces[f][k]);
   endtask

   // reference adjacency builder; pushes the expected count and neighbour words of every vertex
   task automatic model(input int v, input int nf, input int mx, input bit to4, output bit ovf, output bit bad);
      int   cnt [16];
      int   nb  [16][16];
      int   fc  [3];
      int   es  [6] = '{0, 0, 1, 1, 2, 2};
      int   ed  [6] = '{1, 2, 0, 2, 0, 1};
      int   s, d;
      bit   seen;
      exp_t x;
      ovf = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 16; i++) cnt[i] = 0;
      for (int f = 0; f < nf; f++) begin
         for (int k = 0; k < 3; k++) fc[k] = faces[f][k];
`ifdef NBR_BUILDER_INDEX_CHECK_EN
         if (fc[0] < 1 || fc[0] > v || fc[1] < 1 || fc[1] > v || fc[2] < 1 || fc[2] > v) begin
            bad = 1'b1;
            continue;
         end
`endif
         for (int e = 0; e < 6; e++) begin
            s = fc[es[e]] - 1;
            d = fc[ed[e]];
            if (s == d - 1) continue;
            seen = 1'b0;
            for (int j = 0; j < cnt[s]; j++) if (nb[s][j] == d) seen = 1'b1;
            if (seen) continue;
            if (cnt[s] < mx - 1) begin
               nb[s][cnt[s]] = d;
               cnt[s]++;
            end else ovf = 1'b1;
         end
      end
      for (int i = 0; i < v; i++) begin
         x.addr = i * mx;
         x.val  = 32'(cnt[i]);
         if (to4) q1.push_back(x);
         else q0.push_back(x);
         for (int j = 0; j < cnt[i]; j++) begin
            x.addr = i * mx + 1 + j;
            x.val  = 32'(nb[i][j]);
            if (to4) q1.push_back(x);
            else q0.push_back(x);
         end
      end
   endtask

   task automatic prepare(input int v, input int nf, output bit o10, output bit bd10, output bit o4, output bit bd4);
      load_obj(v, nf);
      model(v, nf, 10, 1'b0, o10, bd10);
      model(v, nf, 4, 1'b1, o4, bd4);
   endtask

   // pulses start, then on each DUT's done pops that DUT's expected words and compares its table
   task automatic run_build(input int v, input int nf, output int n0, output int n1, output int lat);
      exp_t e;
      int   c;
      n0 = 0;
      n1 = 0;
      lat = -1;
      @(negedge clk);
      vcount = 32'(v);
      fcount = 32'(nf);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (c = 1; c < 4000 && !(n0 > 0 && n1 > 0); c++) begin
         if (b0.done) begin
            n0++;
            if (lat < 0) lat = c;
            while (q0.size() > 0) begin
               e = q0.pop_front();
               checks++;
               if (nbr0[e.addr] !== e.val) begin
                  errors++;
                  $display("FAIL table_m10 addr=%0d got=%0h want=%0h", e.addr, nbr0[e.addr], e.val);
               end
            end
         end
         if (b1.done) begin
            n1++;
            while (q1.size() > 0) begin
               e = q1.pop_front();
               checks++;
               if (nbr1[e.addr] !== e.val) begin
                  errors++;
                  $display("FAIL table_m4 addr=%0d got=%0h want=%0h", e.addr, nbr1[e.addr], e.val);
               end
            end
         end
         @(negedge clk);
      end
      checks++;
      if (!(n0 > 0 && n1 > 0)) begin
         errors++;
         $display("FAIL done_timeout got n0=%0d n1=%0d want both 1 within 4000 cycles", n0, n1);
      end
      for (int i = 0; i < 3; i++) begin
         if (b0.done) n0++;
         if (b1.done) n1++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (outs0() !== 96'd0) begin
         errors++;
         $display("FAIL reset_outs_m10 got=%h want=0", outs0());
      end
      checks++;
      if (outs1() !== 96'd0) begin
         errors++;
         $display("FAIL reset_outs_m4 got=%h want=0", outs1());
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_face();
      bit o10, bd10, o4, bd4;
      int n0, n1, lat;
      set_face(0, 1, 2, 3);
      prepare(3, 1, o10, bd10, o4, bd4);
      run_build(3, 1, n0, n1, lat);
      checks++;
      if (n0 !== 1 || n1 !== 1) begin
         errors++;
         $display("FAIL single_done_count got=%0d/%0d want=1/1", n0, n1);
      end
      checks++;
      if (nbr0[0] !== 32'd2 || nbr0[11] !== 32'd1 || nbr0[22] !== 32'd2) begin
         errors++;
         $display("FAIL single_spot got=%0d,%0d,%0d want=2,1,2", nbr0[0], nbr0[11], nbr0[22]);
      end
      checks++;
      if (b0.overflow !== 1'b0 || b1.overflow !== 1'b0 || b0.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_flags got ovf=%b/%b busy=%b want 0/0 0", b0.overflow, b1.overflow, b0.busy);
      end
   endtask

   task automatic test_shared_edges();
      bit o10, bd10, o4, bd4;
      int n0, n1, lat;
      set_face(0, 1, 2, 3);
      set_face(1, 1, 3, 4);
      prepare(4, 2, o10, bd10, o4, bd4);
      run_build(4, 2, n0, n1, lat);
      checks++;
      if (n0 !== 1 || n1 !== 1) begin
         errors++;
         $display("FAIL shared_done_count got=%0d/%0d want=1/1", n0, n1);
      end
      checks++;
      if (nbr0[0] !== 32'd3 || nbr0[3] !== 32'd4 || nbr0[30] !== 32'd2) begin
         errors++;
         $display("FAIL shared_spot got=%0d,%0d,%0d want=3,4,2", nbr0[0], nbr0[3], nbr0[30]);
      end
      checks++;
      if (b0.overflow !== o10 || b1.overflow !== o4) begin
         errors++;
         $display("FAIL shared_overflow got=%b/%b want=%b/%b", b0.overflow, b1.overflow, o10, o4);
      end
   endtask

   task automatic test_overflow();
      bit o10, bd10, o4, bd4;
      int n0, n1, lat;
      set_face(0, 1, 2, 3);
      set_face(1, 1, 3, 4);
      set_face(2, 1, 4, 5);
      set_face(3, 1, 5, 6);
      prepare(6, 4, o10, bd10, o4, bd4);
      run_build(6, 4, n0, n1, lat);
      checks++;
      if (n0 !== 1 || n1 !== 1) begin
         errors++;
         $display("FAIL ovf_done_count got=%0d/%0d want=1/1", n0, n1);
      end
      checks++;
      if (b1.overflow !== 1'b1 || b0.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_flag got m4=%b m10=%b want m4=1 m10=0", b1.overflow, b0.overflow);
      end
      checks++;
      if (nbr1[0] !== 32'd3 || nbr1[1] !== 32'd2 || nbr1[2] !== 32'd3 || nbr1[3] !== 32'd4) begin
         errors++;
         $display("FAIL ovf_v0 got=%0d:%0d,%0d,%0d want=3:2,3,4", nbr1[0], nbr1[1], nbr1[2], nbr1[3]);
      end
      checks++;
      if (o4 !== 1'b1 || o10 !== 1'b0) begin
         errors++;
         $display("FAIL ovf_model got m4=%b m10=%b want m4=1 m10=0", o4, o10);
      end
   endtask

   task automatic test_no_faces();
      bit o10, bd10, o4, bd4;
      int n0, n1, lat;
      @(negedge clk);
      fill = 1'b1;
      @(negedge clk);
      fill = 1'b0;
      prepare(2, 0, o10, bd10, o4, bd4);
      run_build(2, 0, n0, n1, lat);
      checks++;
      if (lat < 1 || lat > 5) begin
         errors++;
         $display("FAIL noface_latency got=%0d want 1..5 cycles", lat);
      end
      checks++;
      if (nbr0[0] !== 32'd0 || nbr0[10] !== 32'd0 || nbr1[0] !== 32'd0 || nbr1[4] !== 32'd0) begin
         errors++;
         $display("FAIL noface_clear got=%0h,%0h,%0h,%0h want=0,0,0,0", nbr0[0], nbr0[10], nbr1[0], nbr1[4]);
      end
      checks++;
      if (nbr0[1] !== 32'hDEAD_0001) begin
         errors++;
         $display("FAIL noface_untouched got=%0h want=dead0001", nbr0[1]);
      end
   endtask

   task automatic test_reset_mid_scan();
      bit o10, bd10, o4, bd4;
      int n0, n1, lat, spurious;
      bit found;
      set_face(0, 1, 2, 3);
      load_obj(3, 1);
      @(negedge clk);
      vcount = 32'd3;
      fcount = 32'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (b0.RAM_NBR_EN && b0.RAM_NBR_WE == 4'h0 && (b0.RAM_NBR_A % 10) != 0) found = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL midscan_reach got=no scan read want=scan read within 200 cycles");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs0() !== 96'd0 || outs1() !== 96'd0) begin
         errors++;
         $display("FAIL midscan_outs got=%h/%h want=0/0", outs0(), outs1());
      end
      spurious = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (b0.done || b1.done) spurious++;
      end
      rst_n = 1'b1;
      checks++;
      if (spurious !== 0) begin
         errors++;
         $display("FAIL midscan_done got=%0d want=0", spurious);
      end
      prepare(3, 1, o10, bd10, o4, bd4);
      run_build(3, 1, n0, n1, lat);
      checks++;
      if (n0 !== 1 || n1 !== 1 || b0.overflow !== 1'b0) begin
         errors++;
         $display("FAIL midscan_rerun got done=%0d/%0d ovf=%b want 1/1 0", n0, n1, b0.overflow);
      end
   endtask

   task automatic test_index_check();
      bit o10, bd10, o4, bd4;
      int n0, n1, lat;
      bit want_bad;
`ifdef NBR_BUILDER_INDEX_CHECK_EN
      want_bad = 1'b1;
`else
      want_bad = 1'b0;
`endif
      set_face(0, 1, 2, 3);
      set_face(1, 1, 2, 7);
      prepare(3, 2, o10, bd10, o4, bd4);
      run_build(3, 2, n0, n1, lat);
      checks++;
      if (b0.bad_index !== want_bad || b1.bad_index !== want_bad) begin
         errors++;
         $display("FAIL bad_index got=%b/%b want=%b", b0.bad_index, b1.bad_index, want_bad);
      end
      checks++;
      if (n0 !== 1 || n1 !== 1) begin
         errors++;
         $display("FAIL idx_done_count got=%0d/%0d want=1/1", n0, n1);
      end
      checks++;
      if (q0.size() !== 0 || q1.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_left got=%0d/%0d want=0/0", q0.size(), q1.size());
      end
   endtask

   initial begin
      start  = 1'b0;
      vcount = 32'd0;
      fcount = 32'd0;
      fill   = 1'b0;
      test_reset();
      test_single_face();
      test_shared_edges();
      test_overflow();
      test_no_faces();
      test_reset_mid_scan();
      test_index_check();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/neighbor_builder.md
Name: neighbor_builder

Overview:
- Builds the per-vertex adjacency table in RAM_NBR from the triangle list in RAM_OBJ.
- Sits directly upstream of the averager: the controller asserts averager start only after this block pulses done.
- Output layout: per vertex v (0-indexed), base = v*MAX_NEIGHBOR_COUNT. Word base holds the neighbour count c. Words base+1..base+c hold unique 1-indexed neighbour vertex indices, in first-seen order.

Parameters:
- MAX_NEIGHBOR_COUNT, 10: words per vertex entry; the entry holds at most MAX_NEIGHBOR_COUNT-1 neighbours.
- ADDR_WIDTH, 9: RAM address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  begin build; sampled in IDLE only.
- vertex_count  in  32  V; only low ADDR_WIDTH bits are used for address math.
- face_count  in  32  F.
- RAM_OBJ_Do  in  32  object RAM read data.
- RAM_OBJ_EN  out  1  object RAM enable.
- RAM_OBJ_A  out  ADDR_WIDTH  object RAM address.
- RAM_OBJ_WE  out  4  object RAM write enable; always 0 (read-only use).
- RAM_OBJ_Di  out  32  object RAM write data; always 0.
- RAM_NBR_Do  in  32  neighbour RAM read data.
- RAM_NBR_EN  out  1  neighbour RAM enable.
- RAM_NBR_A  out  ADDR_WIDTH  neighbour RAM address.
- RAM_NBR_WE  out  4  neighbour RAM write enable; 4'b1111 = write.
- RAM_NBR_Di  out  32  neighbour RAM write data.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse at completion.
- overflow  out  1  sticky; a neighbour was dropped because its entry was full. Cleared on start.
- bad_index  out  1  sticky; see Optional Feature. Cleared on start.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset is asynchronous and active low; asserting it mid-operation aborts immediately with no completion pulse. Partial RAM_NBR contents are undefined.
- RAM model: synchronous read. A, EN=1, WE=0 presented in cycle N gives Do sampled in cycle N+1. A write occurs on the edge where EN=1 and WE=4'b1111.
- RAM_OBJ layout: face f (0-indexed) word k is at 3V+1+3f+k. Each word is a 1-indexed vertex index.
- Address arithmetic: base = (idx-1)*MAX_NEIGHBOR_COUNT, truncated to ADDR_WIDTH. Capacity V*MAX_NEIGHBOR_COUNT <= 2^ADDR_WIDTH is the caller's responsibility.
- start while busy is ignored.
- IDLE: on start, clear overflow and bad_index, set busy, go to CLEAR.
- CLEAR: write 0 to word v*MAX_NEIGHBOR_COUNT for v = 0..V-1, one write per cycle. V=0 skips to FINISH.
- FACE_RD: read the 3 indices a, b, c of face f (pipelined, 4 cycles). F=0 or f==F goes to FINISH.
- EDGE: iterate the 6 directed edges in fixed order a->b, a->c, b->a, b->c, c->a, c->b. An edge src->dst with src==dst (degenerate face) is skipped.
- CNT_RD: read count c at base(src).
- SCAN: read words base+1..base+c one per cycle and compare each to dst.
  - Match: abort the insert and move to the next edge.
  - c=0: go straight to APPEND.
- APPEND: if c < MAX_NEIGHBOR_COUNT-1, write dst at base+c+1, then CNT_WR writes c+1 at base. Otherwise set overflow and drop dst.
- After the 6th edge: f++, return to FACE_RD.
- FINISH: drive done=1 for one cycle, busy=0 in the following cycle, return to IDLE.
- Idle bus state: RAM_*_EN=0 and RAM_*_WE=0 whenever not accessing. Never read and write RAM_NBR in the same cycle.

Optional Feature:
- Macro NBR_BUILDER_INDEX_CHECK_EN.
- Defined: after FACE_RD, any of a, b, c equal to 0 or greater than V sets bad_index, and the whole face is skipped (no RAM_NBR writes for it).
- Undefined: no check is performed, bad_index is tied 0, and out-of-range indices are used unchecked.

Test Plan:
- V=3, F=1, face (1,2,3) -> entries: v0 {2: 2,3}, v1 {2: 1,3}, v2 {2: 1,2}; done pulses once; overflow=0.
- V=4, F=2, faces (1,2,3),(1,3,4) -> v0 {3: 2,3,4}, v1 {2: 1,3}, v2 {3: 1,2,4}, v3 {2: 1,3}; duplicates not re-appended.
- MAX_NEIGHBOR_COUNT=4, V=6, faces (1,2,3),(1,3,4),(1,4,5),(1,5,6) -> v0 {3: 2,3,4}, 5 and 6 dropped, overflow=1 after done.
- V=2, F=0 with stale RAM_NBR -> words 0 and MAX_NEIGHBOR_COUNT read back 0; done within V+3 cycles of start.
- rst_n low mid-SCAN -> all outputs 0 immediately, no done. A following start completes test 1 correctly.
- With NBR_BUILDER_INDEX_CHECK_EN defined, V=3, faces (1,2,3),(1,2,7) -> bad_index=1, entries identical to test 1. With the macro undefined, bad_index stays 0.
